// File: rtl/clint_ipi_sequencer.sv
// Serialises per-hart IPI set/clear requests into single-beat register writes to the CLINT msip array.
// Keeps a per-hart shadow of the last successful write, coalesces requests, and latches the first bus error.
module clint_ipi_sequencer #(
  parameter int unsigned          NrHarts       = 10,
  parameter int unsigned          AddrWidth     = 32,
  parameter logic [AddrWidth-1:0] ClintBase     = '0,
  parameter bit                   SkipRedundant = 1'b1,
  localparam int unsigned         HartW         = (NrHarts > 1) ? $clog2(NrHarts) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NrHarts-1:0]   set_i,
  input  logic [NrHarts-1:0]   clr_i,
  output logic                 reg_valid_o,
  output logic                 reg_write_o,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic [31:0]          reg_wdata_o,
  output logic [3:0]           reg_wstrb_o,
  input  logic                 reg_ready_i,
  input  logic                 reg_error_i,
  output logic [NrHarts-1:0]   pending_o,
  output logic [NrHarts-1:0]   msip_shadow_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [HartW-1:0]     err_hart_o,
  input  logic                 err_clr_i
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NrHarts-1:0]   pend_q, pend_d;
  logic [NrHarts-1:0]   val_q, val_d;
  logic [NrHarts-1:0]   shadow_q;
  logic [HartW-1:0]     rr_q;
  logic [HartW-1:0]     cur_q;
  logic [AddrWidth-1:0] addr_q;
  logic                 wbit_q;
  logic                 err_q;
  logic [HartW-1:0]     err_hart_q;

  logic                 pick_found;
  logic [HartW-1:0]     pick;
  int unsigned          rr_idx;
  logic                 launch;
  logic                 complete;

  // Round robin: first pending hart at or after rr+1, wrapping to 0.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    rr_idx     = 0;
    for (int unsigned k = 1; k <= NrHarts; k++) begin
      rr_idx = (32'(rr_q) + k) % NrHarts;
      if (!pick_found && pend_q[HartW'(rr_idx)]) begin
        pick_found = 1'b1;
        pick       = HartW'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          launch  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (reg_ready_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Op slots: launch consumes the slot, a same-cycle request re-queues it (last request wins).
  always_comb begin
    pend_d = pend_q;
    val_d  = val_q;
    if (launch) pend_d[pick] = 1'b0;
    for (int i = 0; i < int'(NrHarts); i++) begin
      if (set_i[i] || clr_i[i]) begin
        if (!(SkipRedundant && (set_i[i] == shadow_q[i]) && !pend_q[i] &&
              !((state_q == REQ) && (cur_q == HartW'(i))))) begin
          pend_d[i] = 1'b1;
          val_d[i]  = set_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q     <= '0;
      val_q      <= '0;
      shadow_q   <= '0;
      rr_q       <= '0;
      cur_q      <= '0;
      addr_q     <= '0;
      wbit_q     <= 1'b0;
      err_q      <= 1'b0;
      err_hart_q <= '0;
    end else begin
      pend_q <= pend_d;
      val_q  <= val_d;
      if (launch) begin
        rr_q   <= pick;
        cur_q  <= pick;
        addr_q <= ClintBase + (AddrWidth'(pick) << 2);
        wbit_q <= val_q[pick];
      end
      if (complete && !reg_error_i) shadow_q[cur_q] <= wbit_q;
      // A completing error beats a same-cycle clear; otherwise the first error hart is kept.
      if (complete && reg_error_i) begin
        err_q <= 1'b1;
        if (!err_q || err_clr_i) err_hart_q <= cur_q;
      end else if (err_clr_i) begin
        err_q      <= 1'b0;
        err_hart_q <= '0;
      end
    end
  end

  assign reg_valid_o   = (state_q == REQ);
  assign reg_write_o   = 1'b1;
  assign reg_addr_o    = addr_q;
  assign reg_wdata_o   = {31'b0, wbit_q};
  assign reg_wstrb_o   = 4'b0001;
  assign pending_o     = pend_q;
  assign msip_shadow_o = shadow_q;
  assign busy_o        = (state_q != IDLE) || (|pend_q);
  assign err_o         = err_q;
  assign err_hart_o    = err_hart_q;

endmodule

// File: tb/tb_clint_ipi_sequencer.sv
// Directed bench for clint_ipi_sequencer: latency, round robin, coalescing, error capture, redundancy skip, reset abort.
module tb_clint_ipi_sequencer;

  localparam int unsigned NrHarts   = 10;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned HartW     = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [NrHarts-1:0]   set_i, clr_i;
  logic                 reg_valid_o, reg_write_o;
  logic [AddrWidth-1:0] reg_addr_o;
  logic [31:0]          reg_wdata_o;
  logic [3:0]           reg_wstrb_o;
  logic                 reg_ready_i, reg_error_i;
  logic [NrHarts-1:0]   pending_o, msip_shadow_o;
  logic                 busy_o, err_o, err_clr_i;
  logic [HartW-1:0]     err_hart_o;

  int  tests = 0;
  int  fails = 0;
  wr_t wr_q[$];

  always #5 clk = ~clk;

  clint_ipi_sequencer #(
    .NrHarts      (NrHarts),
    .AddrWidth    (AddrWidth),
    .ClintBase    (32'h0),
    .SkipRedundant(1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .set_i        (set_i),
    .clr_i        (clr_i),
    .reg_valid_o  (reg_valid_o),
    .reg_write_o  (reg_write_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_wstrb_o  (reg_wstrb_o),
    .reg_ready_i  (reg_ready_i),
    .reg_error_i  (reg_error_i),
    .pending_o    (pending_o),
    .msip_shadow_o(msip_shadow_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .err_hart_o   (err_hart_o),
    .err_clr_i    (err_clr_i)
  );

  // Record every completing bus beat, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_ni && reg_valid_o && reg_ready_i)
      wr_q.push_back('{reg_addr_o, reg_wdata_o, reg_error_i});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_set(input int h);
    set_i    = '0;
    set_i[h] = 1'b1;
    tick();
    set_i = '0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int left = budget;
    while (wr_q.size() < n && left > 0) begin
      tick();
      left--;
    end
    check(tag, 64'(wr_q.size() >= n), 64'h1);
  endtask

  initial begin
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h14; exp_addr[1] = 32'h24; exp_addr[2] = 32'h00; exp_addr[3] = 32'h08;

    rst_ni = 1'b0; set_i = '0; clr_i = '0;
    reg_ready_i = 1'b1; reg_error_i = 1'b0; err_clr_i = 1'b0;
    tick(); tick();
    check("rst_valid",    64'(reg_valid_o),   64'h0);
    check("rst_addr",     64'(reg_addr_o),    64'h0);
    check("rst_wdata",    64'(reg_wdata_o),   64'h0);
    check("rst_pending",  64'(pending_o),     64'h0);
    check("rst_shadow",   64'(msip_shadow_o), 64'h0);
    check("rst_busy",     64'(busy_o),        64'h0);
    check("rst_err",      64'(err_o),         64'h0);
    check("rst_err_hart", 64'(err_hart_o),    64'h0);
    rst_ni = 1'b1;
    tick();

    // Single set: pending at t1, valid at t2, shadow at t3.
    set_i[3] = 1'b1;
    tick();
    set_i = '0;
    check("lat_pending_t1", 64'(pending_o),   64'h008);
    check("lat_valid_t1",   64'(reg_valid_o), 64'h0);
    tick();
    check("lat_valid_t2",   64'(reg_valid_o), 64'h1);
    check("lat_addr_t2",    64'(reg_addr_o),  64'hC);
    check("lat_wdata_t2",   64'(reg_wdata_o), 64'h1);
    check("lat_wstrb_t2",   64'(reg_wstrb_o), 64'h1);
    check("lat_write_t2",   64'(reg_write_o), 64'h1);
    check("lat_busy_t2",    64'(busy_o),      64'h1);
    tick();
    check("lat_shadow_t3",  64'(msip_shadow_o), 64'h008);
    check("lat_valid_t3",   64'(reg_valid_o),   64'h0);
    check("lat_busy_t3",    64'(busy_o),        64'h0);

    // Round robin from rr=0: 5, 9, 0, then late request 2.
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    wr_q.delete();
    set_i[0] = 1'b1; set_i[5] = 1'b1; set_i[9] = 1'b1;
    tick();
    set_i = '0;
    tick();
    check("rr_first_addr", 64'(reg_addr_o), 64'h14);
    set_i[2] = 1'b1;
    tick();
    set_i = '0;
    wait_writes(4, 40, "rr_timeout");
    for (int k = 0; k < 4; k++) begin
      if (k < wr_q.size()) begin
        check($sformatf("rr_order_%0d", k), 64'(wr_q[k].addr),  64'(exp_addr[k]));
        check($sformatf("rr_wdata_%0d", k), 64'(wr_q[k].wdata), 64'h1);
      end
    end
    check("rr_shadow", 64'(msip_shadow_o), 64'h225);

    // set and clr together: set wins, exactly one write.
    wr_q.delete();
    set_i[7] = 1'b1; clr_i[7] = 1'b1;
    tick();
    set_i = '0; clr_i = '0;
    wait_writes(1, 20, "setclr_timeout");
    repeat (6) tick();
    check("setclr_count", 64'(wr_q.size()), 64'h1);
    if (wr_q.size() > 0) begin
      check("setclr_addr",  64'(wr_q[0].addr),  64'h1C);
      check("setclr_wdata", 64'(wr_q[0].wdata), 64'h1);
    end
    check("setclr_shadow", 64'(msip_shadow_o[7]), 64'h1);
    wr_q.delete();
    clr_i[7] = 1'b1;
    tick();
    clr_i = '0;
    wait_writes(1, 20, "clr_timeout");
    repeat (4) tick();
    check("clr_count", 64'(wr_q.size()), 64'h1);
    if (wr_q.size() > 0) check("clr_wdata", 64'(wr_q[0].wdata), 64'h0);
    check("clr_shadow", 64'(msip_shadow_o[7]), 64'h0);

    // Errors: first error hart sticks, shadow untouched, clear resets.
    wr_q.delete();
    reg_error_i = 1'b1;
    pulse_set(4);
    wait_writes(1, 20, "err4_timeout");
    reg_error_i = 1'b0;
    check("err4_err",    64'(err_o),             64'h1);
    check("err4_hart",   64'(err_hart_o),        64'h4);
    check("err4_shadow", 64'(msip_shadow_o[4]), 64'h0);
    reg_error_i = 1'b1;
    pulse_set(7);
    wait_writes(2, 20, "err7_timeout");
    reg_error_i = 1'b0;
    check("err7_err",    64'(err_o),             64'h1);
    check("err7_hart",   64'(err_hart_o),        64'h4);
    check("err7_shadow", 64'(msip_shadow_o[7]), 64'h0);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("errclr_err",  64'(err_o),      64'h0);
    check("errclr_hart", 64'(err_hart_o), 64'h0);

    // Clear held across an erroring completion: the error wins.
    err_clr_i = 1'b1; reg_error_i = 1'b1;
    pulse_set(6);
    wait_writes(3, 20, "errwin_timeout");
    err_clr_i = 1'b0; reg_error_i = 1'b0;
    check("errwin_err",  64'(err_o),      64'h1);
    check("errwin_hart", 64'(err_hart_o), 64'h6);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("errwin_clr", 64'(err_o), 64'h0);

    // Redundant set is dropped while shadow already 1.
    wr_q.delete();
    pulse_set(1);
    wait_writes(1, 20, "skip_prep_timeout");
    tick();
    check("skip_prep_shadow", 64'(msip_shadow_o), 64'h227);
    wr_q.delete();
    set_i[1] = 1'b1;
    repeat (10) begin
      tick();
      check("skip_pending", 64'(pending_o), 64'h0);
    end
    set_i = '0;
    repeat (4) tick();
    check("skip_count", 64'(wr_q.size()), 64'h0);
    check("skip_busy",  64'(busy_o),      64'h0);

    // Stalled write, then reset aborts it.
    reg_ready_i = 1'b0;
    pulse_set(8);
    tick();
    check("stall_valid_0", 64'(reg_valid_o), 64'h1);
    pulse_set(3);
    repeat (4) begin
      check("stall_valid", 64'(reg_valid_o), 64'h1);
      check("stall_addr",  64'(reg_addr_o),  64'h20);
      tick();
    end
    check("stall_pending", 64'(pending_o), 64'h008);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("abort_valid",   64'(reg_valid_o),   64'h0);
    check("abort_pending", 64'(pending_o),     64'h0);
    check("abort_shadow",  64'(msip_shadow_o), 64'h0);
    check("abort_busy",    64'(busy_o),        64'h0);
    reg_ready_i = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1);
  end

endmodule
